mul_operand_issue: RTL and testbench

- Upstream issue stage for the shift-and-add multiplier.
- Buffers operand pairs from a producer in a small FIFO and issues one pair at a time to the multiplier with a single-cycle in_valid pulse.
- Waits for out_valid, captures the product and its issue-to-result latency, and holds the result for a ready/valid consumer.
- Guarantees the multiplier only ever sees in_valid while idle, so its out_valid timing reflects data-dependent latency only.

---
 rtl/mul_issue_pkg.sv | 20 ++
 rtl/mul_issue_fifo.sv | 60 ++++++
 rtl/mul_operand_issue.sv | 175 +++++++++++++++++
 tb/tb_mul_operand_issue.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_pkg.sv
// Shared defaults and types for the multiplier operand issue stage.
package mul_issue_pkg;

  localparam int unsigned WIDTH_DEF = 2;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned LAT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    COOL
  } issue_state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// Synchronous FIFO with a power-of-two depth and free-running wrapping pointers.
module mul_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = logic [3:0]
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output entry_t                   o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mul_operand_issue.sv
// Issue stage feeding the shift-and-add multiplier one operand pair at a time.
// Optional MUL_ISSUE_ZERO_BYPASS_EN retires zero-operand pairs without using the multiplier.
module mul_operand_issue
  import mul_issue_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LAT_W = LAT_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_op_valid,
  output logic                     o_op_ready,
  input  logic [WIDTH-1:0]         i_op_a,
  input  logic [WIDTH-1:0]         i_op_b,
  output logic                     o_mul_in_valid,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  output logic                     o_mul_stall,
  input  logic [2*WIDTH-1:0]       i_mul_o,
  input  logic                     i_mul_out_valid,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [2*WIDTH-1:0]       o_res_o,
  output logic [LAT_W-1:0]         o_res_lat,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  localparam logic [LAT_W-1:0] LatMax = '1;

  issue_state_t       r_state;
  issue_state_t       w_state_next;
  pair_t              w_head;
  pair_t              w_in_pair;
  logic               w_full;
  logic               w_empty;
  logic               w_head_zero;
  logic               w_issue;
  logic               w_bypass;
  logic               w_capture;
  logic               w_accept;
  logic               w_pop;
  logic [LAT_W-1:0]   w_lat_inc;

  logic               r_mul_in_valid;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_res_valid;
  logic [2*WIDTH-1:0] r_res_o;
  logic [LAT_W-1:0]   r_res_lat;

  assign w_in_pair = '{a: i_op_a, b: i_op_b};
  assign w_pop     = w_issue || w_bypass;

  mul_issue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pair_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_op_valid && o_op_ready),
    .i_data  (w_in_pair),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_occupancy)
  );

  // Ready depends on fullness alone, so a same-cycle pop never admits a push when full.
  assign o_op_ready = !w_full;

`ifdef MUL_ISSUE_ZERO_BYPASS_EN
  assign w_head_zero = (w_head.a == '0) || (w_head.b == '0);
`else
  assign w_head_zero = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // A multiplier still finishing from before reset must be drained first.
      r_state <= i_mul_out_valid ? COOL : IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_next = WAIT;
        end else if (w_bypass) begin
          w_state_next = HOLD;
        end
      end
      WAIT:    if (w_capture) w_state_next = HOLD;
      HOLD:    if (w_accept) w_state_next = COOL;
      COOL:    if (!i_mul_out_valid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_bypass  = 1'b0;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_head_zero) begin
            w_bypass = 1'b1;
          end else if (!i_mul_out_valid) begin
            w_issue = 1'b1;
          end
        end
      end
      WAIT:    w_capture = i_mul_out_valid;
      HOLD:    w_accept  = i_res_ready;
      default: ;
    endcase
  end

  // Latency reported at capture includes the capture edge itself.
  assign w_lat_inc = (r_lat_cnt == LatMax) ? LatMax : r_lat_cnt + LAT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mul_in_valid <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_lat_cnt      <= '0;
      r_res_valid    <= 1'b0;
      r_res_o        <= '0;
      r_res_lat      <= '0;
    end else begin
      r_mul_in_valid <= w_issue;
      if (w_issue) begin
        r_mul_a   <= w_head.a;
        r_mul_b   <= w_head.b;
        r_lat_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_lat_cnt <= w_lat_inc;
      end
      if (w_capture) begin
        r_res_o     <= i_mul_o;
        r_res_lat   <= w_lat_inc;
        r_res_valid <= 1'b1;
      end else if (w_bypass) begin
        r_res_o     <= '0;
        r_res_lat   <= '0;
        r_res_valid <= 1'b1;
      end else if (w_accept) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_mul_in_valid = r_mul_in_valid;
  assign o_mul_a        = r_mul_a;
  assign o_mul_b        = r_mul_b;
  assign o_mul_stall    = 1'b0;
  assign o_res_valid    = r_res_valid;
  assign o_res_o        = r_res_o;
  assign o_res_lat      = r_res_lat;

endmodule

// File: tb/tb_mul_operand_issue.sv
// Scoreboard bench for mul_operand_issue with a latency-programmable multiplier model.
`timescale 1ns/1ps
module tb_mul_operand_issue;
  import mul_issue_pkg::*;

  localparam int unsigned W      = WIDTH_DEF;
  localparam int unsigned D      = DEPTH_DEF;
  localparam int unsigned LW     = LAT_W_DEF;
  localparam int unsigned LatSat = (1 << LW) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  op_valid = 1'b0;
  logic                  op_ready;
  logic [W-1:0]          op_a = '0;
  logic [W-1:0]          op_b = '0;
  logic                  mul_in_valid;
  logic [W-1:0]          mul_a;
  logic [W-1:0]          mul_b;
  logic                  mul_stall;
  logic [2*W-1:0]        mul_o;
  logic                  mul_out_valid;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [2*W-1:0]        res_o;
  logic [LW-1:0]         res_lat;
  logic [$clog2(D):0]    occupancy;

  always #5 clk = ~clk;

  mul_operand_issue dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_op_valid      (op_valid),
    .o_op_ready      (op_ready),
    .i_op_a          (op_a),
    .i_op_b          (op_b),
    .o_mul_in_valid  (mul_in_valid),
    .o_mul_a         (mul_a),
    .o_mul_b         (mul_b),
    .o_mul_stall     (mul_stall),
    .i_mul_o         (mul_o),
    .i_mul_out_valid (mul_out_valid),
    .o_res_valid     (res_valid),
    .i_res_ready     (res_ready),
    .o_res_o         (res_o),
    .o_res_lat       (res_lat),
    .o_occupancy     (occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
  } exp_t;

  exp_t          exp_q[$];
  int            lat_q[$];
  int            ext_q[$];
  operand_pair_t iss_q[$];

  // Multiplier model: out_valid first seen at the L-th edge after the issue edge,
  // then held for ext extra cycles.
  int             m_cnt = 0;
  int             m_hc  = 0;
  int             m_ext = 0;
  logic           m_ov  = 1'b0;
  logic           force_ov = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  int             iss_cnt = 0;

  assign mul_out_valid = m_ov | force_ov;
  assign mul_o         = m_prod;

  always @(negedge clk) begin
    logic busy;
    busy = (m_cnt != 0) || m_ov || force_ov;
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ov = 1'b1;
        m_hc = m_ext;
      end
    end else if (m_ov) begin
      if (m_hc == 0) m_ov = 1'b0;
      else m_hc--;
    end
    if (rst_n && mul_in_valid) begin
      iss_cnt++;
      check("issue_while_mul_busy", {31'd0, busy}, 32'd0);
      check("issue_expected", {31'd0, lat_q.size() != 0}, 32'd1);
      if (lat_q.size() != 0) begin
        operand_pair_t p;
        p = iss_q.pop_front();
        check("mul_a", {{(32-W){1'b0}}, mul_a}, {{(32-W){1'b0}}, p.a});
        check("mul_b", {{(32-W){1'b0}}, mul_b}, {{(32-W){1'b0}}, p.b});
        m_cnt  = lat_q.pop_front() - 1;
        m_ext  = ext_q.pop_front();
        m_prod = (2*W)'(mul_a) * (2*W)'(mul_b);
      end
    end
  end

  // Monitor: result handshakes and hold-stability.
  logic           p_valid = 1'b0;
  logic           p_acc   = 1'b0;
  logic [2*W-1:0] p_o     = '0;
  logic [LW-1:0]  p_lat   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
    end else begin
      check("op_ready_vs_occupancy", {31'd0, op_ready}, {31'd0, occupancy < D});
      if (p_valid && !p_acc) begin
        check("res_valid_held", {31'd0, res_valid}, 32'd1);
        check("res_o_stable", 32'(res_o), 32'(p_o));
        check("res_lat_stable", 32'(res_lat), 32'(p_lat));
      end
      if (res_valid && res_ready) begin
        check("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_o", 32'(res_o), 32'(e.prod));
          check("res_lat", 32'(res_lat), e.lat);
        end
      end
      p_valid = res_valid;
      p_acc   = res_ready;
      p_o     = res_o;
      p_lat   = res_lat;
    end
  end

  // 0: never ready, 1: always ready, 2: random
  int rr_mode = 0;
  always begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  function automatic logic is_bypassed(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ISSUE_ZERO_BYPASS_EN
    return (a == '0) || (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                      input int ext);
    int   k;
    exp_t e;
    operand_pair_t p;
    k = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    forever begin
      @(negedge clk);
      if (op_ready) break;
      k++;
      if (k > 300) begin
        check("push_accept_timeout", 32'(k), 32'd0);
        op_valid = 1'b0;
        return;
      end
    end
    e.prod = (2*W)'(a) * (2*W)'(b);
    if (is_bypassed(a, b)) begin
      e.lat = 0;
    end else begin
      e.lat = (lat > int'(LatSat)) ? int'(LatSat) : lat;
      p.a = a;
      p.b = b;
      iss_q.push_back(p);
      lat_q.push_back(lat);
      ext_q.push_back(ext);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_cnt != 0 || m_ov) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_done", {31'd0, exp_q.size() == 0}, 32'd1);
  endtask

  task automatic wait_res_valid(input int budget);
    int k;
    k = 0;
    while (!res_valid && k < budget) begin
      tick(1);
      k++;
    end
    check("res_valid_arrives", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss0;
    int k;

    // Reset values
    tick(3);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_mul_in_valid", {31'd0, mul_in_valid}, 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_mul_stall", {31'd0, mul_stall}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_o", 32'(res_o), 32'd0);
    check("rst_res_lat", 32'(res_lat), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single 3x3, result held until accepted
    iss0 = iss_cnt;
    rr_mode = 0;
    push(2'd3, 2'd3, 3, 0);
    wait_res_valid(50);
    tick(4);
    check("res_held_no_ready", {31'd0, res_valid}, 32'd1);
    check("res_o_before_accept", 32'(res_o), 32'd9);
    check("res_lat_before_accept", 32'(res_lat), 32'd3);
    rr_mode = 1;
    drain(100);
    check("single_issue_count", 32'(iss_cnt - iss0), 32'd1);

    // Fill the FIFO behind an unaccepted result
    rr_mode = 0;
    iss0 = iss_cnt;
    push(2'd1, 2'd2, 4, 0);
    wait_res_valid(50);
    for (int i = 0; i < int'(D); i++) begin
      push(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2 + i, 0);
    end
    check("full_occupancy", 32'(occupancy), D);
    check("full_op_ready", {31'd0, op_ready}, 32'd0);
    check("no_issue_during_hold", 32'(iss_cnt - iss0), 32'd1);
    rr_mode = 1;
    drain(400);
    check("fill_issue_count", 32'(iss_cnt - iss0), D + 1);

    // Finish flag held high beyond completion
    iss0 = iss_cnt;
    push(2'd3, 2'd2, 3, 2);
    push(2'd2, 2'd3, 2, 2);
    push(2'd1, 2'd1, 5, 1);
    drain(200);
    check("ext_issue_count", 32'(iss_cnt - iss0), 32'd3);

    // Reset while waiting on the multiplier, finish flag high across release
    rr_mode = 0;
    push(2'd3, 2'd3, 14, 0);
    push(2'd2, 2'd2, 14, 0);
    push(2'd1, 2'd3, 14, 0);
    k = 0;
    while (m_cnt == 0 && k < 50) begin
      tick(1);
      k++;
    end
    check("mid_reset_in_flight", {31'd0, m_cnt != 0}, 32'd1);
    tick(2);
    rst_n    = 1'b0;
    force_ov = 1'b1;
    tick(1);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_mul_in_valid", {31'd0, mul_in_valid}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    ext_q.delete();
    iss_q.delete();
    rst_n = 1'b1;
    iss0 = iss_cnt;
    push(2'd3, 2'd3, 3, 0);
    tick(8);
    check("cool_blocks_issue", 32'(iss_cnt - iss0), 32'd0);
    k = 0;
    while ((m_cnt != 0 || m_ov) && k < 50) begin
      tick(1);
      k++;
    end
    check("model_idle_before_release", {31'd0, m_cnt == 0 && !m_ov}, 32'd1);
    force_ov = 1'b0;
    rr_mode  = 1;
    drain(100);
    check("issue_after_cool", 32'(iss_cnt - iss0), 32'd1);

    // Zero operand
    iss0 = iss_cnt;
    push(2'd0, 2'd2, 5, 0);
    drain(100);
`ifdef MUL_ISSUE_ZERO_BYPASS_EN
    check("zero_no_issue", 32'(iss_cnt - iss0), 32'd0);
`else
    check("zero_issued", 32'(iss_cnt - iss0), 32'd1);
`endif

    // Random traffic
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(2, 20),
           $urandom_range(0, 2));
      tick($urandom_range(0, 2));
    end
    drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
